reg_alu_exec: RTL

// Parametrised register-file + ALU execution unit. Accepts one packed instruction
// {op, src1, src2, dest} over a valid/ready handshake, reads two registers, computes,

---
 rtl/reg_alu_pkg.sv | 25 ++
 rtl/reg_alu_exec_alu_core.sv | 53 +++++
 rtl/reg_alu_exec.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/reg_alu_pkg.sv
// Shared op-codes and FSM state encoding for the register-file/ALU execution unit.
package reg_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MOV  = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_SHOW
    } state_t;

endpackage

// File: rtl/reg_alu_exec_alu_core.sv
// Combinational ALU: result, carry (ADD carry-out / SUB not-borrow) and reserved-op flag.
module alu_core
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              carry,
    output logic              ill
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign shamt = b[SH_W-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ill   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                res   = diff[DATA_W-1:0];
                carry = ~diff[DATA_W];
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  res = DATA_W'($signed(a) < $signed(b));
            OP_SLTU: res = DATA_W'(a < b);
            OP_MOV:  res = a;
            // Reserved codes still write back, so the result must be a defined zero.
            default: ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_alu_exec.sv
// Register file + ALU execution unit: valid/ready instruction intake, fixed 4-cycle
// pipeline-free FSM, write-back, then stepped display of the result in OUT_W slices.
module reg_alu_exec
    import reg_alu_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NREG     = 16,
    parameter  int OUT_W    = 16,
    parameter  int R0_ZERO  = 1,
    parameter  int AUTO_ADV = 0,
    localparam int REG_AW   = $clog2(NREG),
    localparam int INS_W    = 4 + 3 * REG_AW,
    localparam int NSLICE   = DATA_W / OUT_W,
    localparam int SEL_W    = $clog2(NSLICE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [INS_W-1:0] ins,
    input  logic             step,
    output logic [OUT_W-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    output logic             done,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_ill
);

    state_t              state_reg;
    logic [3:0]          op_reg;
    logic [REG_AW-1:0]   src1_reg;
    logic [REG_AW-1:0]   src2_reg;
    logic [REG_AW-1:0]   dest_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   res_reg;
    logic [DATA_W-1:0]   regs [NREG];
    logic [OUT_W-1:0]    out_data_reg;
    logic [SEL_W-1:0]    out_sel_reg;
    logic                out_valid_reg;
    logic                done_reg;
    logic                flag_z_reg;
    logic                flag_c_reg;
    logic                flag_ill_reg;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic                alu_ill;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;
    logic                wr_en;
    logic [SEL_W-1:0]    sel_next;
    logic                sel_last;
    logic [OUT_W-1:0]    slice_terms [NSLICE];
    logic [OUT_W-1:0]    next_slice;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op    (op_reg),
        .a     (a_reg),
        .b     (b_reg),
        .res   (alu_res),
        .carry (alu_carry),
        .ill   (alu_ill)
    );

    // Register 0 is hard-wired to zero when R0_ZERO is set: reads forced, writes dropped.
    assign rd_a  = ((R0_ZERO != 0) && (src1_reg == '0)) ? '0 : regs[src1_reg];
    assign rd_b  = ((R0_ZERO != 0) && (src2_reg == '0)) ? '0 : regs[src2_reg];
    assign wr_en = (state_reg == ST_WB) && !((R0_ZERO != 0) && (dest_reg == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[dest_reg] <= res_reg;
        end
    end

    // One-hot slice mux for the slice following the one currently shown.
    assign sel_next = out_sel_reg + SEL_W'(1);
    assign sel_last = (out_sel_reg == SEL_W'(NSLICE - 1));

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign slice_terms[gi] = (sel_next == SEL_W'(gi)) ? res_reg[gi*OUT_W +: OUT_W] : '0;
    end

    always_comb begin
        next_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            next_slice = next_slice | slice_terms[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            dest_reg      <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            res_reg       <= '0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            flag_z_reg    <= 1'b0;
            flag_c_reg    <= 1'b0;
            flag_ill_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ins_valid) begin
                        op_reg        <= ins[INS_W-1 -: 4];
                        src1_reg      <= ins[3*REG_AW-1 -: REG_AW];
                        src2_reg      <= ins[2*REG_AW-1 -: REG_AW];
                        dest_reg      <= ins[REG_AW-1:0];
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_READ;
                    end
                end
                ST_READ: begin
                    a_reg     <= rd_a;
                    b_reg     <= rd_b;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_reg      <= alu_res;
                    flag_z_reg   <= (alu_res == '0);
                    flag_c_reg   <= alu_carry;
                    flag_ill_reg <= alu_ill;
                    state_reg    <= ST_WB;
                end
                ST_WB: begin
                    out_data_reg  <= res_reg[OUT_W-1:0];
                    out_sel_reg   <= '0;
                    out_valid_reg <= 1'b1;
                    done_reg      <= 1'b1;
                    state_reg     <= (AUTO_ADV != 0) ? ST_IDLE : ST_SHOW;
                end
                ST_SHOW: begin
                    // Stepping past the last slice leaves it on display but invalid.
                    if (step) begin
                        if (sel_last) begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            out_sel_reg  <= sel_next;
                            out_data_reg <= next_slice;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ins_ready = (state_reg == ST_IDLE);
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign flag_z    = flag_z_reg;
    assign flag_c    = flag_c_reg;
    assign flag_ill  = flag_ill_reg;

endmodule
